// File: rtl/register_file_pkg.sv
// Shared register-file constants and the per-read-port source selection helper.
package register_file_pkg;

    localparam int unsigned CORE_DATA_W    = 16;
    localparam int unsigned CORE_ADDR_W    = 4;
    localparam int unsigned CORE_REG_COUNT = 2 ** CORE_ADDR_W;
    localparam int unsigned CORE_R0_IDX    = 0;

    typedef enum logic [1:0] {
        SRC_STORED = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ZERO   = 2'd2
    } rd_src_e;

    // Read-port priority: hard-wired zero, then same-cycle writeback, then storage.
    function automatic rd_src_e pick_src(input logic is_zero, input logic bypass);
        if (is_zero)
            return SRC_ZERO;
        else if (bypass)
            return SRC_BYPASS;
        else
            return SRC_STORED;
    endfunction

endpackage

// File: rtl/register_file_reg_cell.sv
// One DATA_W-bit storage register with synchronous clear and write enable.
module reg_cell #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (wen)
            q <= d;
    end

endmodule

// File: rtl/register_file.sv
// 16x16 register file: two combinational read ports with write-before-read
// bypass, one clocked write port, optional hard-wired zero R0.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_W   = CORE_DATA_W,
    parameter int unsigned ADDR_W   = CORE_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);

    localparam int unsigned REG_COUNT = 2 ** ADDR_W;

    logic [REG_COUNT-1:0] wen_vec;
    logic [DATA_W-1:0]    stored [REG_COUNT];
    logic                 wr_live;
    logic                 dst_is_r0;
    rd_src_e              src1_sel;
    rd_src_e              src2_sel;

    assign dst_is_r0 = ZERO_REG && (DstReg == ADDR_W'(CORE_R0_IDX));
    assign wr_live   = WriteReg && !rst;

    always_comb begin
        wen_vec = '0;
        if (WriteReg && !dst_is_r0)
            wen_vec[DstReg] = 1'b1;
    end

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_cell
        reg_cell #(.W(DATA_W)) u_cell (
            .clk (clk),
            .rst (rst),
            .wen (wen_vec[i]),
            .d   (DstData),
            .q   (stored[i])
        );
    end

    always_comb begin
        src1_sel = pick_src(ZERO_REG && (SrcReg1 == ADDR_W'(CORE_R0_IDX)),
                            wr_live && (DstReg == SrcReg1));
        src2_sel = pick_src(ZERO_REG && (SrcReg2 == ADDR_W'(CORE_R0_IDX)),
                            wr_live && (DstReg == SrcReg2));
    end

    always_comb begin
        SrcData1 = stored[SrcReg1];
        case (src1_sel)
            SRC_ZERO:   SrcData1 = '0;
            SRC_BYPASS: SrcData1 = DstData;
            default:    SrcData1 = stored[SrcReg1];
        endcase
    end

    always_comb begin
        SrcData2 = stored[SrcReg2];
        case (src2_sel)
            SRC_ZERO:   SrcData2 = '0;
            SRC_BYPASS: SrcData2 = DstData;
            default:    SrcData2 = stored[SrcReg2];
        endcase
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;

    int unsigned total;
    int unsigned bad;
    logic [15:0] sra_in;
    logic [15:0] sra_out;

    register_file #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] idx, input logic [15:0] val);
        WriteReg = 1'b1;
        DstReg   = idx;
        DstData  = val;
        step();
        WriteReg = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        WriteReg = 1'b0;
        DstReg   = '0;
        DstData  = '0;
        SrcReg1  = '0;
        SrcReg2  = '0;
        step();
        rst = 1'b0;

        // reset state on every index, both ports
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(15 - i);
            #1;
            check_val($sformatf("reset_p1_r%0d", i), SrcData1, 16'h0000);
            check_val($sformatf("reset_p2_r%0d", 15 - i), SrcData2, 16'h0000);
        end

        // plain write then read
        write_reg(4'd5, 16'hA5A5);
        SrcReg1 = 4'd5; SrcReg2 = 4'd5; #1;
        check_val("wr_r5_p1", SrcData1, 16'hA5A5);
        check_val("wr_r5_p2", SrcData2, 16'hA5A5);
        SrcReg1 = 4'd4; SrcReg2 = 4'd6; #1;
        check_val("wr_r4_clean", SrcData1, 16'h0000);
        check_val("wr_r6_clean", SrcData2, 16'h0000);

        // bypass
        write_reg(4'd3, 16'h1111);
        SrcReg1 = 4'd3; SrcReg2 = 4'd5; #1;
        check_val("byp_stored", SrcData1, 16'h1111);
        WriteReg = 1'b1; DstReg = 4'd4; DstData = 16'h2222; #1;
        check_val("byp_other_dst", SrcData1, 16'h1111);
        DstReg = 4'd3; SrcReg2 = 4'd3; #1;
        check_val("byp_p1", SrcData1, 16'h2222);
        check_val("byp_p2", SrcData2, 16'h2222);
        step();
        WriteReg = 1'b0; #1;
        check_val("byp_after_edge", SrcData1, 16'h2222);
        SrcReg1 = 4'd4; #1;
        check_val("byp_r4_untouched", SrcData1, 16'h0000);

        // R0 hard-wired zero, even under bypass
        WriteReg = 1'b1; DstReg = 4'd0; DstData = 16'hFFFF;
        SrcReg1 = 4'd0; SrcReg2 = 4'd0; #1;
        check_val("r0_same_p1", SrcData1, 16'h0000);
        check_val("r0_same_p2", SrcData2, 16'h0000);
        step();
        WriteReg = 1'b0; #1;
        check_val("r0_next_p2", SrcData2, 16'h0000);
        SrcReg1 = 4'd5; #1;
        check_val("r0_no_alias_r5", SrcData1, 16'hA5A5);

        // reset beats a concurrent write; bypass off during reset
        write_reg(4'd7, 16'h00FF);
        rst = 1'b1; WriteReg = 1'b1; DstReg = 4'd7; DstData = 16'h1234;
        SrcReg1 = 4'd7; SrcReg2 = 4'd5; #1;
        check_val("rst_no_bypass", SrcData1, 16'h00FF);
        step();
        rst = 1'b0; WriteReg = 1'b0; #1;
        check_val("rst_r7_cleared", SrcData1, 16'h0000);
        check_val("rst_r5_cleared", SrcData2, 16'h0000);

        // shifter round trip: SRA by 1 of R2, written back
        sra_in  = 16'h8001;
        sra_out = 16'hC000;
        write_reg(4'd2, sra_in);
        SrcReg1 = 4'd2; #1;
        check_val("shf_operand", SrcData1, 16'h8001);
        write_reg(4'd2, sra_out);
        #1;
        check_val("shf_writeback", SrcData1, 16'hC000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
